// File: rtl/pia_input_conditioner_pkg.sv
// Shared constants for the PIA input conditioner: button bit map and bus widths.
package pia_input_pkg;

  localparam int unsigned BTN_X     = 0;
  localparam int unsigned BTN_B     = 1;
  localparam int unsigned BTN_Y     = 2;
  localparam int unsigned BTN_A     = 3;
  localparam int unsigned BTN_UP    = 4;
  localparam int unsigned BTN_DOWN  = 5;
  localparam int unsigned BTN_LEFT  = 6;
  localparam int unsigned BTN_RIGHT = 7;

  localparam int unsigned NUM_BTN = 8;
  localparam int unsigned NUM_SW  = 4;

endpackage

// File: rtl/pia_input_conditioner_debounce_bit.sv
// Single-input conditioner: pad synchroniser, persistence debouncer and accept-high pulse.
module debounce_bit #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic q_o,
  output logic rise_o
);

  localparam int unsigned    CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   stable_d, stable_q;
  logic [CntW-1:0]        cnt_d, cnt_q;
  logic                   rise_d, rise_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    if (s != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = s;
        rise_d   = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

  assign q_o    = stable_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/pia_input_conditioner.sv
// Board buttons/DIP switches -> clean active-low buttons and switches for the PIA.
// Optional autofire on button A is built when AUTOFIRE_EN is defined.
module pia_input_conditioner
  import pia_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned AUTOFIRE_PERIOD = 1250000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  input  logic [NUM_SW-1:0]  sw_raw_i,
  input  logic               autofire_en_i,
  output logic [NUM_BTN-1:0] buttons_o,
  output logic [NUM_SW-1:0]  sw_o,
  output logic [NUM_BTN-1:0] press_o
);

  logic [NUM_BTN-1:0] btn_stable, btn_rise;
  logic [NUM_SW-1:0]  sw_stable, sw_rise;
  logic [NUM_BTN-1:0] buttons_d, buttons_q;
  logic [NUM_SW-1:0]  sw_d, sw_q;
  logic [NUM_BTN-1:0] press_d, press_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .raw_i (btn_raw_i[i]),
      .q_o   (btn_stable[i]),
      .rise_o(btn_rise[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .raw_i (sw_raw_i[i]),
      .q_o   (sw_stable[i]),
      .rise_o(sw_rise[i])
    );
  end

  logic unused_sw_rise;
  assign unused_sw_rise = ^sw_rise;

`ifdef AUTOFIRE_EN
  localparam int unsigned     AfW   = (AUTOFIRE_PERIOD > 1) ? $clog2(AUTOFIRE_PERIOD) : 1;
  localparam logic [AfW-1:0]  AfMax = AfW'(AUTOFIRE_PERIOD - 1);

  logic [AfW-1:0] af_cnt_d, af_cnt_q;
  logic           af_active_d, af_active_q;
  logic           unused_rise_a;
  assign unused_rise_a = btn_rise[BTN_A];

  always_comb begin
    buttons_d   = ~btn_stable;
    sw_d        = sw_stable;
    press_d     = btn_rise;
    af_cnt_d    = '0;
    af_active_d = 1'b0;
    if (autofire_en_i && btn_stable[BTN_A]) begin
      af_active_d = 1'b1;
      if (!af_active_q) begin
        buttons_d[BTN_A] = 1'b0;
      end else if (af_cnt_q == AfMax) begin
        buttons_d[BTN_A] = ~buttons_q[BTN_A];
      end else begin
        af_cnt_d         = af_cnt_q + 1'b1;
        buttons_d[BTN_A] = buttons_q[BTN_A];
      end
    end
    // Every 1->0 transition of A counts as a press, including autofire re-presses.
    press_d[BTN_A] = buttons_q[BTN_A] & ~buttons_d[BTN_A];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      af_cnt_q    <= '0;
      af_active_q <= 1'b0;
    end else begin
      af_cnt_q    <= af_cnt_d;
      af_active_q <= af_active_d;
    end
  end
`else
  logic unused_autofire_en;
  assign unused_autofire_en = autofire_en_i;

  always_comb begin
    buttons_d = ~btn_stable;
    sw_d      = sw_stable;
    press_d   = btn_rise;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buttons_q <= '1;
      sw_q      <= '0;
      press_q   <= '0;
    end else begin
      buttons_q <= buttons_d;
      sw_q      <= sw_d;
      press_q   <= press_d;
    end
  end

  assign buttons_o = buttons_q;
  assign sw_o      = sw_q;
  assign press_o   = press_q;

endmodule

// File: tb/tb_pia_input_conditioner.sv
// Scoreboard bench for pia_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, AUTOFIRE_PERIOD=6).
module tb_pia_input_conditioner;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] btn_raw_i;
  logic [3:0] sw_raw_i;
  logic       autofire_en_i;
  logic [7:0] buttons_o;
  logic [3:0] sw_o;
  logic [7:0] press_o;

  typedef struct {
    logic [7:0] btn;
    logic [3:0] sw;
    logic [7:0] press;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_i = ~clk_i;

  pia_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .AUTOFIRE_PERIOD(6)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .btn_raw_i    (btn_raw_i),
    .sw_raw_i     (sw_raw_i),
    .autofire_en_i(autofire_en_i),
    .buttons_o    (buttons_o),
    .sw_o         (sw_o),
    .press_o      (press_o)
  );

  function automatic exp_t mk(logic [7:0] b, logic [3:0] s, logic [7:0] p);
    exp_t e;
    e.btn   = b;
    e.sw    = s;
    e.press = p;
    return e;
  endfunction

  // Reset held 4 samples with all buttons raw-pressed, then release reset, later release buttons.
  task automatic test_reset();
    exp_t e;
    rst_ni = 1'b0; btn_raw_i = 8'hFF; sw_raw_i = 4'h0; autofire_en_i = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (c <= 10)      sb.push_back(mk(8'hFF, 4'h0, 8'h00));
      else if (c == 11) sb.push_back(mk(8'h00, 4'h0, 8'hFF));
      else if (c <= 20) sb.push_back(mk(8'h00, 4'h0, 8'h00));
      else              sb.push_back(mk(8'hFF, 4'h0, 8'h00));
    end
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk_i);
      e = sb.pop_front();
      n_checks++;
      if (buttons_o !== e.btn || sw_o !== e.sw || press_o !== e.press) begin
        n_fail++;
        $display("FAIL reset c=%0d got btn=%h sw=%h press=%h exp btn=%h sw=%h press=%h",
                 c, buttons_o, sw_o, press_o, e.btn, e.sw, e.press);
      end
      if (c == 4)  rst_ni = 1'b1;
      if (c == 14) btn_raw_i = 8'h00;
    end
  endtask

  task automatic test_clean_press();
    exp_t e;
    btn_raw_i = 8'h10;
    for (int c = 1; c <= 22; c++) begin
      if (c <= 6)       sb.push_back(mk(8'hFF, 4'h0, 8'h00));
      else if (c == 7)  sb.push_back(mk(8'hEF, 4'h0, 8'h10));
      else if (c <= 15) sb.push_back(mk(8'hEF, 4'h0, 8'h00));
      else              sb.push_back(mk(8'hFF, 4'h0, 8'h00));
    end
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk_i);
      e = sb.pop_front();
      n_checks++;
      if (buttons_o !== e.btn || sw_o !== e.sw || press_o !== e.press) begin
        n_fail++;
        $display("FAIL clean_press c=%0d got btn=%h sw=%h press=%h exp btn=%h sw=%h press=%h",
                 c, buttons_o, sw_o, press_o, e.btn, e.sw, e.press);
      end
      if (c == 9) btn_raw_i = 8'h00;
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    btn_raw_i = 8'h80;
    for (int c = 1; c <= 12; c++) sb.push_back(mk(8'hFF, 4'h0, 8'h00));
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_i);
      e = sb.pop_front();
      n_checks++;
      if (buttons_o !== e.btn || sw_o !== e.sw || press_o !== e.press) begin
        n_fail++;
        $display("FAIL glitch c=%0d got btn=%h sw=%h press=%h exp btn=%h sw=%h press=%h",
                 c, buttons_o, sw_o, press_o, e.btn, e.sw, e.press);
      end
      if (c == 3) btn_raw_i = 8'h00;
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    btn_raw_i = 8'h0A; sw_raw_i = 4'h5;
    for (int c = 1; c <= 18; c++) begin
      if (c <= 6)       sb.push_back(mk(8'hFF, 4'h0, 8'h00));
      else if (c == 7)  sb.push_back(mk(8'hF5, 4'h5, 8'h0A));
      else if (c <= 14) sb.push_back(mk(8'hF5, 4'h5, 8'h00));
      else              sb.push_back(mk(8'hFF, 4'h0, 8'h00));
    end
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk_i);
      e = sb.pop_front();
      n_checks++;
      if (buttons_o !== e.btn || sw_o !== e.sw || press_o !== e.press) begin
        n_fail++;
        $display("FAIL simultaneous c=%0d got btn=%h sw=%h press=%h exp btn=%h sw=%h press=%h",
                 c, buttons_o, sw_o, press_o, e.btn, e.sw, e.press);
      end
      if (c == 8) begin
        btn_raw_i = 8'h00; sw_raw_i = 4'h0;
      end
    end
  endtask

  // Reset lands two cycles into a press; acceptance needs the full count again afterwards.
  task automatic test_reset_mid_debounce();
    exp_t e;
    btn_raw_i = 8'h01;
    for (int c = 1; c <= 22; c++) begin
      if (c <= 10)      sb.push_back(mk(8'hFF, 4'h0, 8'h00));
      else if (c == 11) sb.push_back(mk(8'hFE, 4'h0, 8'h01));
      else if (c <= 19) sb.push_back(mk(8'hFE, 4'h0, 8'h00));
      else              sb.push_back(mk(8'hFF, 4'h0, 8'h00));
    end
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk_i);
      e = sb.pop_front();
      n_checks++;
      if (buttons_o !== e.btn || sw_o !== e.sw || press_o !== e.press) begin
        n_fail++;
        $display("FAIL reset_mid c=%0d got btn=%h sw=%h press=%h exp btn=%h sw=%h press=%h",
                 c, buttons_o, sw_o, press_o, e.btn, e.sw, e.press);
      end
      if (c == 2)  rst_ni = 1'b0;
      if (c == 4)  rst_ni = 1'b1;
      if (c == 13) btn_raw_i = 8'h00;
    end
  endtask

  // A held 30 cycles with autofire requested; steady press when the feature is not built.
  task automatic test_autofire();
    exp_t       e;
    logic [7:0] b;
    logic [7:0] p;
    autofire_en_i = 1'b1;
    btn_raw_i     = 8'h08;
    for (int c = 1; c <= 40; c++) begin
      b = 8'hFF;
      p = 8'h00;
      if (c >= 7 && c <= 36) begin
`ifdef AUTOFIRE_EN
        if (((c - 7) / 6) % 2 == 0) b = 8'hF7;
        if ((c - 7) % 12 == 0)      p = 8'h08;
`else
        b = 8'hF7;
        if (c == 7) p = 8'h08;
`endif
      end
      sb.push_back(mk(b, 4'h0, p));
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_i);
      e = sb.pop_front();
      n_checks++;
      if (buttons_o !== e.btn || sw_o !== e.sw || press_o !== e.press) begin
        n_fail++;
        $display("FAIL autofire c=%0d got btn=%h sw=%h press=%h exp btn=%h sw=%h press=%h",
                 c, buttons_o, sw_o, press_o, e.btn, e.sw, e.press);
      end
      if (c == 30) btn_raw_i = 8'h00;
    end
    autofire_en_i = 1'b0;
  endtask

  initial begin
    rst_ni        = 1'b0;
    btn_raw_i     = 8'h00;
    sw_raw_i      = 4'h0;
    autofire_en_i = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_reset_mid_debounce();
    test_autofire();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
